// File: rtl/simon_pkg.sv
// Shared constants, types and helpers for the Simon 32/64 key schedule.
// Z0 is written with index 0 at its leftmost (most significant) bit.
package simon_pkg;

    localparam int WORD      = 16;
    localparam int ROUNDS    = 32;
    localparam int KEY_WORDS = 4;

    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    localparam logic [WORD-1:0] RC = 16'hFFFC;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    function automatic logic [WORD-1:0] simon_ror(input logic [WORD-1:0] word,
                                                  input int unsigned     n);
        return (word >> n) | (word << (WORD - n));
    endfunction

    function automatic logic z0_bit(input logic [5:0] idx);
        return Z0[6'd61 - idx];
    endfunction

endpackage

// File: rtl/simon_key_step.sv
// Combinational Simon 32/64 next-round-key function:
// rk[i] = C ^ z ^ rk[i-4] ^ tmp ^ ROR1(tmp), tmp = ROR3(rk[i-1]) ^ rk[i-3].
module simon_key_step
    import simon_pkg::*;
(
    input  logic [WORD-1:0] rk_m1,
    input  logic [WORD-1:0] rk_m3,
    input  logic [WORD-1:0] rk_m4,
    input  logic            zbit,
    output logic [WORD-1:0] rk_next
);

    logic [WORD-1:0] mix;
    logic [WORD-1:0] tmp;

    assign mix     = simon_ror(rk_m1, 3) ^ rk_m3;
    assign tmp     = mix ^ simon_ror(mix, 1);
    // The z bit only ever touches bit 0 of the round constant.
    assign rk_next = RC ^ {{(WORD-1){1'b0}}, zbit} ^ rk_m4 ^ tmp;

endmodule

// File: rtl/simon_key_expand.sv
// Iterative Simon 32/64 key expansion: loads the master key, then writes one
// round key per cycle into a local register file with a combinational read port.
module simon_key_expand
    import simon_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_valid,
    output logic                    key_ready,
    input  logic [KEY_WORDS*WORD-1:0] keytext,
    input  logic [4:0]              rk_addr,
    output logic [WORD-1:0]         rk_data,
    output logic                    keys_valid,
    output logic                    busy
);

    localparam int CNT_W = $clog2(ROUNDS);

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [WORD-1:0] rk [ROUNDS];
    logic [WORD-1:0] rk_next;
    logic            zbit;

    assign zbit = z0_bit(6'(cnt - CNT_W'(KEY_WORDS)));

    simon_key_step u_step (
        .rk_m1   (rk[cnt - CNT_W'(1)]),
        .rk_m3   (rk[cnt - CNT_W'(3)]),
        .rk_m4   (rk[cnt - CNT_W'(4)]),
        .zbit    (zbit),
        .rk_next (rk_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            key_ready  <= 1'b1;
            keys_valid <= 1'b0;
            busy       <= 1'b0;
            for (int r = 0; r < ROUNDS; r++) rk[r] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // key_ready is high in both of these states, so key_valid alone accepts.
                    if (key_valid) begin
                        for (int w = 0; w < KEY_WORDS; w++)
                            rk[w] <= keytext[w*WORD +: WORD];
                        cnt        <= CNT_W'(KEY_WORDS);
                        keys_valid <= 1'b0;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    rk[cnt] <= rk_next;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ROUNDS - 1)) begin
                        keys_valid <= 1'b1;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    key_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rk_data = '0;
        if (int'(rk_addr) < ROUNDS) rk_data = rk[rk_addr];
    end

endmodule

// File: tb/tb_simon_key_expand.sv
// Scoreboard bench for simon_key_expand: an independent key-schedule model
// queues expected round keys at key acceptance; they are compared on completion.
module tb_simon_key_expand;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] keytext;
    logic [4:0]  rk_addr;
    logic [15:0] rk_data;
    logic        keys_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] dut_keys [32];
    logic [61:0] zseq = 62'b11111010001001010110000111001101111101000100101011000011100110;

    simon_key_expand dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .keytext    (keytext),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data),
        .keys_valid (keys_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rr(input logic [15:0] w, input int n);
        return (w >> n) | (w << (16 - n));
    endfunction

    function automatic logic [15:0] rl(input logic [15:0] w, input int n);
        return (w << n) | (w >> (16 - n));
    endfunction

    task automatic push_model(input logic [63:0] key);
        logic [15:0] k [32];
        logic [15:0] t;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rr(k[i-1], 3) ^ k[i-3];
            t = t ^ rr(t, 1);
            k[i] = 16'hFFFC ^ {15'b0, zseq[61-(i-4)]} ^ k[i-4] ^ t;
        end
        for (int i = 0; i < 32; i++) exp_q.push_back(k[i]);
    endtask

    function automatic logic [31:0] encrypt(input logic [31:0] pt);
        logic [15:0] x, y, t;
        x = pt[31:16];
        y = pt[15:0];
        for (int r = 0; r < 32; r++) begin
            t = x;
            x = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ dut_keys[r];
            y = t;
        end
        return {x, y};
    endfunction

    // Drive one key across a clock edge; returns at T0 + 1.
    task automatic send_key(input logic [63:0] key);
        keytext   = key;
        key_valid = 1'b1;
        push_model(key);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    // Run from T0+1 until keys_valid (bounded); reports latency, busy cycles and rk[4] at T1.
    task automatic run_expansion(output int lat, output int bcnt, output logic [15:0] rk4);
        lat  = -1;
        bcnt = busy ? 1 : 0;
        rk4  = 16'hxxxx;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                rk_addr = 5'd4;
                #1;
                rk4 = rk_data;
            end
            if (keys_valid) begin
                lat = c;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic check_schedule(input string name);
        logic [15:0] e;
        for (int a = 0; a < 32; a++) begin
            rk_addr = 5'(a);
            #1;
            dut_keys[a] = rk_data;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s rk[%0d]: got %h, scoreboard empty", name, a, rk_data);
            end else begin
                e = exp_q.pop_front();
                if (rk_data !== e) begin
                    n_fail++;
                    $display("FAIL %s rk[%0d]: got %h expected %h", name, a, rk_data, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        key_valid = 1'b0;
        keytext   = '0;
        rk_addr   = '0;
        #2 rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset key_ready: got %b expected 1", key_ready); end
        n_checks++;
        if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL reset keys_valid: got %b expected 0", keys_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        for (int a = 0; a < 32; a++) begin
            rk_addr = 5'(a);
            #1;
            n_checks++;
            if (rk_data !== 16'h0) begin n_fail++; $display("FAIL reset rk[%0d]: got %h expected 0000", a, rk_data); end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got ready=%b busy=%b expected 1 0", key_ready, busy);
        end
    endtask

    task automatic test_vector();
        int lat, bcnt;
        logic [15:0] rk4;
        logic [15:0] k0 [4];
        logic [31:0] ct;
        k0[0] = 16'h0100; k0[1] = 16'h0908; k0[2] = 16'h1110; k0[3] = 16'h1918;
        send_key(64'h1918111009080100);
        n_checks++;
        if (key_ready !== 1'b0 || busy !== 1'b1 || keys_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL vec_t0_flags: got ready=%b busy=%b kv=%b expected 0 1 0", key_ready, busy, keys_valid);
        end
        for (int a = 0; a < 4; a++) begin
            rk_addr = 5'(a);
            #1;
            n_checks++;
            if (rk_data !== k0[a]) begin n_fail++; $display("FAIL vec_load rk[%0d]: got %h expected %h", a, rk_data, k0[a]); end
        end
        run_expansion(lat, bcnt, rk4);
        n_checks++;
        if (rk4 !== 16'h71C3) begin n_fail++; $display("FAIL vec_rk4: got %h expected 71c3", rk4); end
        n_checks++;
        if (lat != 28) begin n_fail++; $display("FAIL vec_latency: got %0d expected 28", lat); end
        n_checks++;
        if (bcnt != 28) begin n_fail++; $display("FAIL vec_busy_cycles: got %0d expected 28", bcnt); end
        n_checks++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL vec_done_flags: got ready=%b busy=%b expected 1 0", key_ready, busy);
        end
        check_schedule("vec");
        ct = encrypt(32'h65656877);
        n_checks++;
        if (ct !== 32'hC69BE9BB) begin n_fail++; $display("FAIL vec_cipher: got %h expected c69be9bb", ct); end
    endtask

    task automatic test_ignore_during_expand();
        int lat, bcnt;
        logic [15:0] rk4;
        send_key(64'h0123456789ABCDEF);
        repeat (5) @(posedge clk);
        #1;
        keytext   = 64'hDEADBEEFCAFEF00D;
        key_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (key_ready !== 1'b0) begin n_fail++; $display("FAIL ignore_ready: got %b expected 0", key_ready); end
        end
        key_valid = 1'b0;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            if (keys_valid) begin lat = c; break; end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (lat < 0) begin n_fail++; $display("FAIL ignore_timeout: keys_valid=%b expected 1 within 40 cycles", keys_valid); end
        check_schedule("ignore");
        // Quiet cycle in DONE must hold the schedule.
        @(posedge clk);
        #1;
        n_checks++;
        if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL ignore_hold_kv: got %b expected 1", keys_valid); end
    endtask

    task automatic test_rekey_zero();
        int lat, bcnt;
        logic [15:0] rk4;
        send_key(64'h0);
        n_checks++;
        if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL rekey_kv_drop: got %b expected 0", keys_valid); end
        run_expansion(lat, bcnt, rk4);
        n_checks++;
        if (rk4 !== 16'hFFFD) begin n_fail++; $display("FAIL rekey_rk4: got %h expected fffd", rk4); end
        n_checks++;
        if (lat != 28) begin n_fail++; $display("FAIL rekey_latency: got %0d expected 28", lat); end
        check_schedule("rekey");
    endtask

    task automatic test_reset_mid_expand();
        int lat, bcnt;
        logic [15:0] rk4;
        send_key(64'hFEDCBA9876543210);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if (key_ready !== 1'b1 || keys_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flags: got ready=%b kv=%b busy=%b expected 1 0 0", key_ready, keys_valid, busy);
        end
        for (int a = 0; a < 32; a += 5) begin
            rk_addr = 5'(a);
            #1;
            n_checks++;
            if (rk_data !== 16'h0) begin n_fail++; $display("FAIL midrst rk[%0d]: got %h expected 0000", a, rk_data); end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_key(64'h1B1A191813121110);
        run_expansion(lat, bcnt, rk4);
        n_checks++;
        if (lat != 28) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 28", lat); end
        check_schedule("after_reset");
    endtask

    initial begin
        test_reset();
        test_vector();
        test_ignore_during_expand();
        test_rekey_zero();
        test_reset_mid_expand();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_key_expand.md
Name: simon_key_expand

Overview:
- Iterative key-schedule stage for Simon 32/64.
- Sits directly upstream of the Simon round datapath. Takes a 64-bit master key and expands it, one word per cycle, into 32 16-bit round keys held in a local register file.
- The round datapath reads round keys through a combinational read port. `keys_valid` tells it the full schedule is available.
- Decouples key expansion from encryption, so a key is expanded once and reused for many plaintexts.

Parameters:
- WORD, 16, round-key/word width in bits (fixed for 32/64; kept for readability).
- ROUNDS, 32, number of round keys generated and stored.
- KEY_WORDS, 4, master-key words m (k0..k3).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  `keytext` holds a new master key to expand.
- key_ready  output  1  block can accept a key this cycle.
- keytext  input  64  master key; k0 = [15:0], k1 = [31:16], k2 = [47:32], k3 = [63:48].
- rk_addr  input  5  round index to read.
- rk_data  output  16  round key at `rk_addr` (combinational).
- keys_valid  output  1  all ROUNDS keys are present and belong to the last accepted key.
- busy  output  1  expansion in progress.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low (`rst_n`).
- Reset values: state = IDLE; all round-key registers = 0; round counter = 0; `keys_valid` = 0; `busy` = 0; `key_ready` = 1.
- States:
  - IDLE: `key_ready` = 1, `keys_valid` = 0.
  - EXPAND: `key_ready` = 0, `busy` = 1.
  - DONE: `key_ready` = 1, `keys_valid` = 1.
- Handshake: a key is accepted on a rising edge where `key_valid` && `key_ready`. `key_valid` is ignored while `key_ready` = 0; there is no queueing.
- Acceptance edge T0:
  - rk[0..3] <= k0..k3.
  - counter i <= 4.
  - `keys_valid` <= 0.
  - state <= EXPAND.
- EXPAND, one key per edge:
  - tmp = ROR3(rk[i-1]) ^ rk[i-3]; tmp = tmp ^ ROR1(tmp).
  - rk[i] = 0xFFFC ^ z0[i-4] ^ rk[i-4] ^ tmp. The z bit is XORed into bit 0 only.
  - i increments each edge.
  - On the edge that writes rk[31] (T28): state <= DONE, `keys_valid` <= 1.
- Latency: `keys_valid` rises 28 cycles after the acceptance edge. `busy` is high for exactly 28 cycles.
- z0 is the 62-bit Simon constant sequence 11111010001001010110000111001101111101000100101011000011100110, with index 0 at the leftmost bit. Only indices 0..27 are used.
- ROR is a rotate within 16 bits. All arithmetic is XOR/NOT; there is no carry.
- Re-key from DONE: a new handshake immediately drops `keys_valid` on that edge and restarts expansion. Old keys are overwritten progressively.
- Read port:
  - `rk_data` = rk[`rk_addr`] combinationally, in every state.
  - During EXPAND it returns partially updated contents. Consumers gate on `keys_valid`.
  - `rk_addr` >= ROUNDS is unreachable for ROUNDS = 32. If ROUNDS is reduced, out-of-range addresses return 0.
- Reset mid-EXPAND: immediate return to reset values, with no partial `keys_valid`.
- Simultaneous `key_valid` and reset deassertion: a key is not accepted until the first edge with `rst_n` = 1.

Decomposition:
- Package `simon_pkg`:
  - WORD, ROUNDS, KEY_WORDS.
  - Z0 constant (62 bits).
  - Round constant C = 16'hFFFC.
  - State enum {IDLE, EXPAND, DONE}.
  - Function `simon_ror(word, n)`.
- One natural sub-module, `simon_key_step`: combinational next-key function taking (rk[i-1], rk[i-3], rk[i-4], zbit) and producing rk[i].
- The top holds the FSM, counter and 32x16 register file.

Test Plan:
- Reset with `key_valid` = 0 -> `key_ready` = 1, `keys_valid` = 0, `busy` = 0, `rk_data` = 0 for all addresses.
- Accept `keytext` = 64'h1918111009080100 -> rk[0..3] = 0100, 0908, 1110, 1918 after T0; rk[4] = 16'h71C3; `keys_valid` high exactly 28 cycles after T0.
- Same key, then feed rk[0..31] to the existing `simon_for` round datapath with plaintext 32'h65656877 -> ciphertext 32'hC69BE9BB.
- Pulse `key_valid` during EXPAND with a different key -> ignored, `key_ready` = 0, final schedule matches the first key.
- Re-key from DONE with 64'h0 -> `keys_valid` drops on the acceptance edge and rises 28 cycles later. rk[4] = 16'hFFFD (0xFFFC ^ z0[0]).
- Assert `rst_n` = 0 at cycle 10 of EXPAND -> all outputs at reset values immediately (asynchronous). A fresh key after release completes normally.
